isram_responder: RTL and testbench

Read-only instruction-SRAM responder sitting on the slave end of the AR/R read channel driven by the instruction cache's miss path. Accepts one read address at a time, waits a fixed or pseudo-random latency, and returns one 32-bit word with a response code. Also provides a simple write port for preloading the array from the bench or the loader.

---
 rtl/isram_responder_pkg.sv | 39 +++
 rtl/isram_responder_lfsr8.sv | 33 +++
 rtl/isram_responder.sv | 198 +++++++++++++++++++
 tb/tb_isram_responder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isram_responder_pkg
// Description : Shared definitions for the instruction-SRAM read responder:
//               FSM state encoding, AXI-style response codes, LFSR seed and
//               the address-window decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package isram_responder_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t c_ST_IDLE = 2'd0;
  localparam state_t c_ST_WAIT = 2'd1;
  localparam state_t c_ST_RESP = 2'd2;

  // Read response codes
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_RESP_DECERR = 2'b11;

  // Seed loaded into the delay LFSR on reset
  localparam logic [7:0] c_LFSR_SEED = 8'hA5;

  // Width of the wait counter; holds LATENCY plus up to 15 random cycles
  localparam int c_CNT_W = 8;

  // True when base <= addr < base + span. Done in 33 bits so that an address
  // below the base wraps to a huge offset and fails the single compare.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (off < span);
  endfunction

endpackage
`default_nettype wire

// File: rtl/isram_responder_lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : lfsr8
// Description : 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seeded
//               on reset and advancing on every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr8
  import isram_responder_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] r_q;
  logic       w_fb;

  assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

  // Shift left every cycle, feedback into bit 0
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= c_LFSR_SEED;
    end else begin
      r_q <= {r_q[6:0], w_fb};
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/isram_responder.sv
`default_nettype none
// ============================================================================
// Module      : isram_responder
// Description : Read-only instruction SRAM on the slave side of an AR/R read
//               channel. One outstanding read; the response is captured at
//               the address handshake and returned after a fixed (or, with
//               RAND_DELAY_EN defined, LFSR-jittered) delay. A separate write
//               port preloads the array and is independent of the FSM.
// Options     : `define RAND_DELAY_EN adds LATENCY + (lfsr[3:0] & MAX_RAND).
// Revision    : 1.0 - initial release
// ============================================================================
module isram_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter int          MAX_RAND  = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  input  logic        mem_we,
  input  logic [31:0] mem_waddr,
  input  logic [31:0] mem_wdata
);
  import isram_responder_pkg::*;

  localparam int          c_IDX_W = $clog2(DEPTH);
  localparam logic [32:0] c_SPAN  = 33'(DEPTH) << 2;

  // --------------------------------------------------------------------------
  // Delay source
  // --------------------------------------------------------------------------
  logic [c_CNT_W-1:0] w_delay;

`ifdef RAND_DELAY_EN
  logic [7:0] w_lfsr;
  logic       w_unused_lfsr_hi;

  lfsr8 u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (w_lfsr)
  );

  // Only the low nibble feeds the jitter
  assign w_unused_lfsr_hi = ^w_lfsr[7:4];
  assign w_delay = c_CNT_W'(LATENCY) + c_CNT_W'(w_lfsr[3:0] & 4'(MAX_RAND));
`else
  localparam int c_UNUSED_MAX_RAND = MAX_RAND;
  assign w_delay = c_CNT_W'(LATENCY);
`endif

  // --------------------------------------------------------------------------
  // Address decode for both the read and the preload port
  // --------------------------------------------------------------------------
  logic               w_rd_in_range;
  logic               w_rd_aligned;
  logic [c_IDX_W-1:0] w_rd_idx;
  logic               w_wr_in_range;
  logic               w_wr_aligned;
  logic [c_IDX_W-1:0] w_wr_idx;

  assign w_rd_in_range = addr_in_range(araddr, ADDR_BASE, c_SPAN);
  assign w_rd_aligned  = (araddr[1:0] == 2'b00);
  assign w_rd_idx      = c_IDX_W'((araddr - ADDR_BASE) >> 2);

  assign w_wr_in_range = addr_in_range(mem_waddr, ADDR_BASE, c_SPAN);
  assign w_wr_aligned  = (mem_waddr[1:0] == 2'b00);
  assign w_wr_idx      = c_IDX_W'((mem_waddr - ADDR_BASE) >> 2);

  // --------------------------------------------------------------------------
  // Storage array (contents survive reset)
  // --------------------------------------------------------------------------
  logic [31:0] r_mem [DEPTH];

  // Preload writes land whenever the target is a valid aligned word
  always_ff @(posedge clock) begin
    if (mem_we && w_wr_in_range && w_wr_aligned) begin
      r_mem[w_wr_idx] <= mem_wdata;
    end
  end

  // Response that would be returned for the address currently on araddr
  logic [31:0] w_rsp_data;
  logic [1:0]  w_rsp_code;

  // Error checks take priority over the array read
  always_comb begin
    w_rsp_data = 32'h0;
    w_rsp_code = c_RESP_OKAY;
    if (!w_rd_in_range) begin
      w_rsp_code = c_RESP_DECERR;
    end else if (!w_rd_aligned) begin
      w_rsp_code = c_RESP_SLVERR;
    end else begin
      w_rsp_data = r_mem[w_rd_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Transaction FSM
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_arready;
  logic               r_rvalid;
  logic [31:0]        r_rdata;
  logic [1:0]         r_rresp;
  logic               w_ar_hs;
  logic               w_r_hs;
  logic               w_arready_nxt;
  logic               w_rvalid_nxt;
  logic               w_capture;

  assign w_ar_hs = arvalid && r_arready;
  assign w_r_hs  = r_rvalid && rready;

  // State and wait-counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; a zero delay skips WAIT entirely
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_ST_IDLE: begin
        if (w_ar_hs) begin
          w_cnt_nxt   = w_delay;
          w_state_nxt = (w_delay != '0) ? c_ST_WAIT : c_ST_RESP;
        end
      end
      c_ST_WAIT: begin
        if (r_cnt <= c_CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = c_ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_W'(1);
        end
      end
      c_ST_RESP: begin
        if (w_r_hs) begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode; handshakes are registered from the next state
  always_comb begin
    w_arready_nxt = (w_state_nxt == c_ST_IDLE);
    w_rvalid_nxt  = (w_state_nxt == c_ST_RESP);
    w_capture     = (r_state == c_ST_IDLE) && w_ar_hs;
  end

  // Registered channel outputs; data is frozen from accept until R handshake
  always_ff @(posedge clock) begin
    if (reset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0;
      r_rresp   <= c_RESP_OKAY;
    end else begin
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      if (w_capture) begin
        r_rdata <= w_rsp_data;
        r_rresp <= w_rsp_code;
      end
    end
  end

  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

endmodule
`default_nettype wire

// File: tb/tb_isram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_isram_responder
// Description : Self-checking bench for isram_responder. A LATENCY=1 instance
//               covers single reads, errors, backpressure, write collision
//               and reset; a LATENCY=0 instance covers back-to-back reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isram_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT1  = 1;
`ifdef RAND_DELAY_EN
  localparam bit RAND_MODE = 1'b1;
`else
  localparam bit RAND_MODE = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic [31:0] araddr = 32'h0;
  logic        arready, rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        arvalid0 = 1'b0, rready0 = 1'b0;
  logic [31:0] araddr0 = 32'h0;
  logic        arready0, rvalid0;
  logic [31:0] rdata0;
  logic [1:0]  rresp0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_waddr = 32'h0, mem_wdata = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] mon_d [$];
  logic [1:0]  mon_r [$];

  isram_responder #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .LATENCY(LAT1), .MAX_RAND(15)) dut (
    .clock(clock), .reset(reset), .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata));

  isram_responder #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .LATENCY(0), .MAX_RAND(15)) dut0 (
    .clock(clock), .reset(reset), .arvalid(arvalid0), .arready(arready0), .araddr(araddr0),
    .rvalid(rvalid0), .rready(rready0), .rdata(rdata0), .rresp(rresp0),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Collect completed R transfers of the zero-latency instance
  always @(negedge clock) begin
    if (!reset && rvalid0 && rready0) begin
      mon_d.push_back(rdata0);
      mon_r.push_back(rresp0);
    end
  end

  // Reference behaviour: window check, alignment check, then array lookup
  function automatic logic [33:0] model_read(input logic [31:0] addr);
    longint unsigned a = 64'(addr);
    longint unsigned b = 64'(BASE);
    if (a < b || a >= b + 4 * DEPTH) return {2'b11, 32'h0};
    if (addr % 4 != 0)               return {2'b10, 32'h0};
    return {2'b00, model_mem[int'((a - b) / 4)]};
  endfunction

  function automatic bit lat_ok(input int lat, input int base_lat);
    if (RAND_MODE) return (lat >= base_lat && lat <= base_lat + 15);
    return (lat == base_lat);
  endfunction

  task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
    logic [33:0] m;
    @(negedge clock);
    mem_we = 1'b1; mem_waddr = addr; mem_wdata = data;
    @(posedge clock); #1;
    mem_we = 1'b0;
    m = model_read(addr);
    if (m[33:32] == 2'b00) model_mem[int'((addr - BASE) >> 2)] = data;
  endtask

  // Drive one read on the LATENCY=1 instance; hold = RESP cycles with rready low
  task automatic do_read(input logic [31:0] addr, input int hold,
                         output logic [31:0] d, output logic [1:0] r, output int lat,
                         output logic stable, output logic ar_after, output logic rv_after);
    int guard;
    d = 32'h0; r = 2'b00; lat = -1; stable = 1'b0; ar_after = 1'b0; rv_after = 1'b1;
    @(negedge clock);
    arvalid = 1'b1; araddr = addr; rready = (hold == 0);
    guard = 0;
    while (!arready && guard < 200) begin @(negedge clock); guard++; end
    if (!arready) begin arvalid = 1'b0; return; end
    @(posedge clock); #1;
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 200) begin @(posedge clock); #1; lat++; end
    if (!rvalid) begin lat = -1; return; end
    d = rdata; r = rresp; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (!rvalid || rdata !== d || rresp !== r || arready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) begin @(negedge clock); rready = 1'b1; end
    @(posedge clock); #1;
    ar_after = arready; rv_after = rvalid;
    @(negedge clock);
    rready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock); reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (arready !== 1'b0) begin n_fail++; $display("FAIL reset_arready got=%b exp=0", arready); end
    n_checks++; if (rvalid !== 1'b0)  begin n_fail++; $display("FAIL reset_rvalid got=%b exp=0", rvalid); end
    n_checks++; if (rdata !== 32'h0)  begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    n_checks++; if (rresp !== 2'b00)  begin n_fail++; $display("FAIL reset_rresp got=%b exp=00", rresp); end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (arready !== 1'b1) begin n_fail++; $display("FAIL reset_release_arready got=%b exp=1", arready); end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] r; int lat; logic st, aa, rv;
    mem_write(BASE, 32'h0000_0413);
    do_read(BASE, 0, d, r, lat, st, aa, rv);
    n_checks++; if (d !== 32'h0000_0413) begin n_fail++; $display("FAIL basic_rdata got=%h exp=00000413", d); end
    n_checks++; if (r !== 2'b00) begin n_fail++; $display("FAIL basic_rresp got=%b exp=00", r); end
    n_checks++; if (!lat_ok(lat, LAT1)) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT1); end
    n_checks++; if (aa !== 1'b1 || rv !== 1'b0) begin n_fail++; $display("FAIL basic_return_idle got arready=%b rvalid=%b exp 1/0", aa, rv); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    logic [1:0]  er [4];
    logic [31:0] ed [4];
    logic [31:0] d; logic [1:0] r; int lat; logic st, aa, rv;
    addrs[0] = 32'h8000_0002; er[0] = 2'b10; ed[0] = 32'h0;
    addrs[1] = 32'h7FFF_FFFC; er[1] = 2'b11; ed[1] = 32'h0;
    addrs[2] = 32'h8000_1000; er[2] = 2'b11; ed[2] = 32'h0;
    addrs[3] = 32'h8000_0FFC; er[3] = 2'b00; ed[3] = model_mem[DEPTH-1];
    for (int i = 0; i < 4; i++) begin
      do_read(addrs[i], 0, d, r, lat, st, aa, rv);
      n_checks++; if (r !== er[i]) begin n_fail++; $display("FAIL err_rresp addr=%h got=%b exp=%b", addrs[i], r, er[i]); end
      n_checks++; if (d !== ed[i]) begin n_fail++; $display("FAIL err_rdata addr=%h got=%h exp=%h", addrs[i], d, ed[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [1:0] r; int lat; logic st, aa, rv;
    logic [33:0] m;
    m = model_read(BASE + 32'd28);
    do_read(BASE + 32'd28, 5, d, r, lat, st, aa, rv);
    n_checks++; if (d !== m[31:0]) begin n_fail++; $display("FAIL bp_rdata got=%h exp=%h", d, m[31:0]); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable got=%b exp=1", st); end
    n_checks++; if (aa !== 1'b1 || rv !== 1'b0) begin n_fail++; $display("FAIL bp_return_idle got arready=%b rvalid=%b exp 1/0", aa, rv); end
  endtask

  task automatic test_same_cycle_write();
    logic [31:0] d; logic [1:0] r; int lat, guard; logic st, aa, rv;
    mem_write(BASE + 32'd20, 32'h1111_1111);
    @(negedge clock);
    guard = 0;
    while (!arready && guard < 200) begin @(negedge clock); guard++; end
    arvalid = 1'b1; araddr = BASE + 32'd20; rready = 1'b1;
    mem_we = 1'b1; mem_waddr = BASE + 32'd20; mem_wdata = 32'h2222_2222;
    @(posedge clock); #1;
    arvalid = 1'b0; mem_we = 1'b0;
    model_mem[5] = 32'h2222_2222;
    lat = 0;
    while (!rvalid && lat < 200) begin @(posedge clock); #1; lat++; end
    n_checks++; if (rvalid !== 1'b1 || rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL collide_old_data got rvalid=%b rdata=%h exp 1/11111111", rvalid, rdata); end
    @(posedge clock); #1;
    @(negedge clock); rready = 1'b0;
    do_read(BASE + 32'd20, 0, d, r, lat, st, aa, rv);
    n_checks++; if (d !== 32'h2222_2222) begin n_fail++; $display("FAIL collide_new_data got=%h exp=22222222", d); end
  endtask

  task automatic test_reset_mid();
    int guard; logic seen, ar_bad;
    seen = 1'b0; ar_bad = 1'b0;
    @(negedge clock);
    guard = 0;
    while (!arready && guard < 200) begin @(negedge clock); guard++; end
    arvalid = 1'b1; araddr = BASE; rready = 1'b1;
    @(posedge clock); #1;
    arvalid = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      if (rvalid) seen = 1'b1;
      if (arready) ar_bad = 1'b1;
    end
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (arready !== 1'b1) begin n_fail++; $display("FAIL midreset_arready_after got=%b exp=1", arready); end
    repeat (20) begin @(posedge clock); #1; if (rvalid) seen = 1'b1; end
    n_checks++; if (ar_bad !== 1'b0) begin n_fail++; $display("FAIL midreset_arready_in_reset got=%b exp=0", ar_bad); end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_response got=%b exp=0", seen); end
    rready = 1'b0;
  endtask

  task automatic test_back_to_back();
    localparam int NB = 6;
    logic [31:0] addrs [NB];
    logic [33:0] m;
    int acc [NB];
    int guard, sp;
    bit sp_ok;
    for (int k = 0; k < NB; k++) addrs[k] = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    addrs[2] = 32'h8000_2000;
    mon_d.delete(); mon_r.delete();
    @(negedge clock);
    rready0 = 1'b1; arvalid0 = 1'b1; araddr0 = addrs[0];
    for (int k = 0; k < NB; k++) begin
      guard = 0;
      while (!arready0 && guard < 50) begin @(negedge clock); guard++; end
      @(posedge clock); #1;
      acc[k] = cyc;
      if (k < NB - 1) araddr0 = addrs[k + 1]; else arvalid0 = 1'b0;
      @(negedge clock);
    end
    guard = 0;
    while (mon_d.size() < NB && guard < 50) begin @(negedge clock); guard++; end
    for (int k = 1; k < NB; k++) begin
      sp = acc[k] - acc[k - 1];
      sp_ok = RAND_MODE ? (sp >= 2 && sp <= 17) : (sp == 2);
      n_checks++; if (!sp_ok) begin n_fail++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=2", k, sp); end
    end
    n_checks++; if (mon_d.size() != NB) begin n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", mon_d.size(), NB); end
    for (int k = 0; k < NB && k < mon_d.size(); k++) begin
      m = model_read(addrs[k]);
      n_checks++; if (mon_d[k] !== m[31:0] || mon_r[k] !== m[33:32]) begin
        n_fail++; $display("FAIL b2b_data idx=%0d got=%h/%b exp=%h/%b", k, mon_d[k], mon_r[k], m[31:0], m[33:32]);
      end
    end
    rready0 = 1'b0;
  endtask

  task automatic test_random_reads();
    logic [31:0] addr, d; logic [1:0] r; int lat, hold, sel; logic st, aa, rv;
    logic [33:0] m;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0)
        mem_write(BASE + 32'($urandom_range(0, 4 * DEPTH - 1)), $urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0:       addr = BASE - 32'(4 * $urandom_range(1, 1000));
        1:       addr = BASE + 32'h1000 + 32'($urandom_range(0, 10000));
        2:       addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        default: addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      endcase
      hold = $urandom_range(0, 3);
      m = model_read(addr);
      do_read(addr, hold, d, r, lat, st, aa, rv);
      n_checks++; if (d !== m[31:0]) begin n_fail++; $display("FAIL rand_rdata addr=%h got=%h exp=%h", addr, d, m[31:0]); end
      n_checks++; if (r !== m[33:32]) begin n_fail++; $display("FAIL rand_rresp addr=%h got=%b exp=%b", addr, r, m[33:32]); end
      n_checks++; if (!lat_ok(lat, LAT1)) begin n_fail++; $display("FAIL rand_latency addr=%h got=%0d exp=%0d", addr, lat, LAT1); end
      n_checks++; if (st !== 1'b1 || aa !== 1'b1 || rv !== 1'b0) begin
        n_fail++; $display("FAIL rand_handshake addr=%h got stable=%b arready=%b rvalid=%b exp 1/1/0", addr, st, aa, rv);
      end
    end
  endtask

`ifdef RAND_DELAY_EN
  task automatic test_lfsr_repeat();
    int l1 [64];
    logic [31:0] d; logic [1:0] r; int lat; logic st, aa, rv;
    pulse_reset();
    for (int i = 0; i < 64; i++) begin
      do_read(BASE, 0, d, r, lat, st, aa, rv);
      l1[i] = lat;
      n_checks++; if (!(lat >= LAT1 && lat <= LAT1 + 15)) begin n_fail++; $display("FAIL lfsr_range idx=%0d got=%0d exp %0d..%0d", i, lat, LAT1, LAT1 + 15); end
    end
    pulse_reset();
    for (int i = 0; i < 64; i++) begin
      do_read(BASE, 0, d, r, lat, st, aa, rv);
      n_checks++; if (lat != l1[i]) begin n_fail++; $display("FAIL lfsr_repeat idx=%0d got=%0d exp=%0d", i, lat, l1[i]); end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    for (int i = 0; i < DEPTH; i++) mem_write(BASE + 32'(4 * i), $urandom);
    test_basic();
    test_errors();
    test_backpressure();
    test_same_cycle_write();
    test_back_to_back();
    test_random_reads();
    test_reset_mid();
`ifdef RAND_DELAY_EN
    test_lfsr_repeat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
